pipelined_adder_tree: RTL and testbench

- Parametrised, pipelined signed adder tree that sums NUM_OPS operands of WIDTH bits each.
- Successor to the fixed two-stage, three-operand adder. Adds:
  - operand-count and width generics;
  - valid/ready flow control with backpressure;
  - per-result overflow detection;
  - selectable wrap or saturate output mode.
- Sits between operand producers and downstream accumulate/activation logic.

---
 rtl/pipelined_adder_tree.sv | 182 ++++++++++++++++++
 tb/tb_pipelined_adder_tree.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree
//
// Pipelined signed adder tree. It sums NUM_OPS two's-complement operands of
// WIDTH bits each. Level k adds adjacent pairs from level k-1 at WIDTH+k bits,
// so no intermediate result is ever truncated. There is one register stage
// per level. The last stage registers the WIDTH-bit result and an overflow
// flag. That result is either wrapped or saturated to the signed WIDTH range,
// depending on SATURATE.
//
// Handshake (both sides): a transfer happens on a rising clk edge where valid
// and ready are both high. A producer holds valid and data stable until that
// edge. Ready never depends on valid on the same side. in_ready is a function
// only of the stage valid bits and out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand vector valid
//   in_ready   block can accept an operand vector this cycle
//   in_data    operand i at bits [i*WIDTH +: WIDTH]
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   signed sum, wrapped or saturated
//   out_ovf    full-precision sum fell outside the signed WIDTH range
//   busy       at least one stage holds a valid entry

module pipelined_adder_tree #(
    parameter int WIDTH    = 32,
    parameter int NUM_OPS  = 4,
    parameter int SATURATE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_ovf,
    output logic                     busy
);

    // One pipeline stage per tree level. Missing operands are zero-padded up
    // to the next power of two.
    localparam int LEVELS = $clog2(NUM_OPS);
    localparam int PAD    = 1 << LEVELS;
    localparam int SW     = WIDTH + LEVELS;

    // Stage i (0-based) holds the level i+1 partial sums. Stage LEVELS-1 is
    // the output register.
    logic [LEVELS-1:0] vld_q;
    logic [LEVELS-1:0] vld_d;
    logic [LEVELS-1:0] up_vld;
    logic [LEVELS-1:0] rdy;
    logic [LEVELS-1:0] load;

    // Upstream valid for each stage: in_valid feeds stage 0, and stage i-1
    // feeds stage i.
    assign up_vld = LEVELS'({vld_q, in_valid});

    // A stage can take a new entry when either condition holds:
    //   - some stage at or after it is empty, so the chain ahead can shift;
    //   - the output is draining this cycle.
    // This lets bubbles collapse while the output is stalled.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < LEVELS; i++) begin
            rdy[i] = out_ready;
            for (int j = i; j < LEVELS; j++) begin
                if (!vld_q[j]) begin
                    rdy[i] = 1'b1;
                end
            end
        end
    end

    assign load = rdy & up_vld;

    // When a stage is ready but its upstream is empty, it takes a bubble.
    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < LEVELS; i++) begin
            if (rdy[i]) begin
                vld_d[i] = up_vld[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N  = PAD >> k;
        localparam int LW = WIDTH + k;

        logic signed [LW-2:0] src   [2*N];
        logic signed [LW-1:0] sum_d [N];

        if (k == 1) begin : g_leaf
            for (genvar i = 0; i < 2 * N; i++) begin : g_op
                if (i < NUM_OPS) begin : g_real
                    assign src[i] = in_data[i*WIDTH +: WIDTH];
                end else begin : g_zero
                    assign src[i] = '0;
                end
            end
        end else begin : g_inner
            assign src = g_lvl[k-1].g_reg.sum_q;
        end

        // Sign-extend both addends by one bit so the pair sum cannot overflow.
        for (genvar j = 0; j < N; j++) begin : g_add
            assign sum_d[j] = {src[2*j][LW-2], src[2*j]}
                            + {src[2*j+1][LW-2], src[2*j+1]};
        end

        // The last level is not stored at full width. The output register
        // below captures it after wrap or saturate.
        if (k < LEVELS) begin : g_reg
            logic signed [LW-1:0] sum_q [N];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < N; j++) begin
                        sum_q[j] <= '0;
                    end
                end else if (load[k-1]) begin
                    for (int j = 0; j < N; j++) begin
                        sum_q[j] <= sum_d[j];
                    end
                end
            end
        end
    end

    logic [SW-1:0]     root;
    logic [SW-WIDTH:0] top_bits;
    logic              ovf_d;
    logic [WIDTH-1:0]  sat_val;
    logic [WIDTH-1:0]  out_data_d;
    logic [WIDTH-1:0]  out_data_q;
    logic              out_ovf_q;

    assign root = g_lvl[LEVELS].sum_d[0];

    // The sum fits in WIDTH signed bits exactly when bits [SW-1:WIDTH-1] are
    // all copies of the sign bit.
    assign top_bits = root[SW-1:WIDTH-1];
    assign ovf_d    = !((&top_bits) || !(|top_bits));
    assign sat_val  = root[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};

    always_comb begin
        out_data_d = root[WIDTH-1:0];
        if ((SATURATE != 0) && ovf_d) begin
            out_data_d = sat_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else if (load[LEVELS-1]) begin
            out_data_q <= out_data_d;
            out_ovf_q  <= ovf_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[LEVELS-1];
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = |vld_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree. Three instances share clk, rst, the input
// handshake and out_ready:
//   u_wrap  default parameters (wrap mode)
//   u_sat   SATURATE=1
//   u_n3    NUM_OPS=3, which takes the low three operands
// All three have two levels, so their results line up cycle for cycle.

module tb_pipelined_adder_tree;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           out_ready;
    logic [4*W-1:0] in_data;

    logic           w_in_ready, w_out_valid, w_out_ovf, w_busy;
    logic [W-1:0]   w_out_data;
    logic           s_in_ready, s_out_valid, s_out_ovf, s_busy;
    logic [W-1:0]   s_out_data;
    logic           n_in_ready, n_out_valid, n_out_ovf, n_busy;
    logic [W-1:0]   n_out_data;

    int             checks   = 0;
    int             failures = 0;
    logic [W-1:0]   exp_q[$];

    always #5 clk = ~clk;

    pipelined_adder_tree #(.WIDTH(W), .NUM_OPS(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .out_ovf(w_out_ovf), .busy(w_busy)
    );

    pipelined_adder_tree #(.WIDTH(W), .NUM_OPS(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_ovf(s_out_ovf), .busy(s_busy)
    );

    pipelined_adder_tree #(.WIDTH(W), .NUM_OPS(3), .SATURATE(0)) u_n3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_data(in_data[3*W-1:0]), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_data(n_out_data), .out_ovf(n_out_ovf), .busy(n_busy)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4*W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
    endfunction

    // Drives one vector into an empty pipeline with out_ready high. It then
    // checks the cycle-exact pattern:
    //   - the vector is accepted on the first edge;
    //   - the result is presented after the next edge;
    //   - the result drains on the edge after that.
    task automatic run_vec(input string tag, input logic [4*W-1:0] vec,
                           input logic [W-1:0] exp_w, input logic exp_wo,
                           input logic [W-1:0] exp_s, input logic exp_so,
                           input logic [W-1:0] exp_n);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = vec;
        #1;
        check({tag, "_in_ready"}, W'(w_in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        check({tag, "_c1_busy"}, W'(w_busy), 1);
        check({tag, "_c1_valid"}, W'(w_out_valid), 0);
        tick();
        check({tag, "_c2_valid"}, W'(w_out_valid), 1);
        check({tag, "_wrap_data"}, w_out_data, exp_w);
        check({tag, "_wrap_ovf"}, W'(w_out_ovf), W'(exp_wo));
        check({tag, "_sat_data"}, s_out_data, exp_s);
        check({tag, "_sat_ovf"}, W'(s_out_ovf), W'(exp_so));
        check({tag, "_n3_data"}, n_out_data, exp_n);
        check({tag, "_c2_busy"}, W'(w_busy), 1);
        tick();
        check({tag, "_c3_valid"}, W'(w_out_valid), 0);
        check({tag, "_c3_busy"}, W'(w_busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent;
        int got;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        tick();
        tick();
        check("rst_out_valid", W'(w_out_valid), 0);
        check("rst_busy", W'(w_busy), 0);
        check("rst_out_data", w_out_data, 0);
        check("rst_out_ovf", W'(w_out_ovf), 0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", W'(w_in_ready), 1);

        // Each row gives the vector, then wrap data/ovf, sat data/ovf, and the
        // three-operand sum.
        run_vec("v1234", pack4(1, 2, 3, 4), 32'd10, 1'b0, 32'd10, 1'b0, 32'd6);
        run_vec("vmix", pack4(-5, 7, -100, 3), 32'hFFFFFFA1, 1'b0, 32'hFFFFFFA1, 1'b0, 32'hFFFFFF9E);
        run_vec("vposovf", pack4(32'h7FFFFFFF, 1, 0, 0), 32'h80000000, 1'b1, 32'h7FFFFFFF, 1'b1, 32'h80000000);
        run_vec("vnegovf", pack4(32'h80000000, -1, 0, 0), 32'h7FFFFFFF, 1'b1, 32'h80000000, 1'b1, 32'h7FFFFFFF);
        run_vec("vmaxall", pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
                32'hFFFFFFFC, 1'b1, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFD);
        run_vec("vminall", pack4(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000),
                32'h00000000, 1'b1, 32'h80000000, 1'b1, 32'h80000000);
        run_vec("vposedge", pack4(32'h7FFFFFFE, 1, 0, 0), 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF);
        run_vec("vnegedge", pack4(32'h80000000, 1, -1, 0), 32'h80000000, 1'b0, 32'h80000000, 1'b0, 32'h80000000);

        // Backpressure: six vectors whose sums are 1..6, with out_ready held
        // low for cycles 0..3. The pipeline fills after two accepts. Its head
        // then stays parked until cycle 4, and the six results drain on
        // cycles 4..9.
        sent = 0;
        got  = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (sent < 6);
            in_data   = (sent < 6) ? pack4(sent + 3, -2, 1, -1) : '0;
            #1;
            check($sformatf("bp_in_ready_c%0d", cyc), W'(w_in_ready), W'(cyc < 2 || cyc >= 4));
            check($sformatf("bp_out_valid_c%0d", cyc), W'(w_out_valid), W'(cyc >= 2 && cyc <= 9));
            if (w_out_valid) begin
                check($sformatf("bp_sb_nonempty_c%0d", cyc), W'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check($sformatf("bp_data_c%0d", cyc), w_out_data, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && w_in_ready) begin
                exp_q.push_back(W'(sent + 1));
                sent++;
            end else if (in_valid) begin
                // Not accepted on this edge, so the value on in_data must be
                // ignored.
                in_data = {4{32'h5A5A5A5A}};
            end
            tick();
        end
        check("bp_sent", W'(sent), 6);
        check("bp_got", W'(got), 6);
        check("bp_busy_end", W'(w_busy), 0);

        // Reset with two vectors in flight.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = pack4(5, 6, 7, 8);
        tick();
        in_data   = pack4(1, 1, 1, 1);
        tick();
        in_valid  = 1'b0;
        in_data   = '0;
        check("mid_pre_valid", W'(w_out_valid), 1);
        check("mid_pre_busy", W'(w_busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", W'(w_out_valid), 0);
        check("mid_rst_busy", W'(w_busy), 0);
        check("mid_rst_n3_valid", W'(n_out_valid), 0);
        check("mid_rst_n3_busy", W'(n_busy), 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("mid_idle_valid_%0d", i), W'(w_out_valid), 0);
            check($sformatf("mid_idle_n3_valid_%0d", i), W'(n_out_valid), 0);
        end
        run_vec("vpost", pack4(10, 20, 30, 40), 32'd100, 1'b0, 32'd100, 1'b0, 32'd60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
